hdb3_decoder: RTL and testbench
===============================

# hdb3_decoder

Receive-side HDB3 decoder and the counterpart of the transmit polarity stage. It takes the bipolar line symbol stream (2-bit signed codes, one per enabled clock), detects bipolar violations, removes 000V / B00V substitutions and emits the recovered NRZ bit stream. It also flags line-code errors and keeps a saturating error count for the link-status logic.

## Interface
- ERR_W, default 8: width of the saturating error counter.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- sym_in  input  2  line symbol: 00 = zero, 01 = positive pulse, 11 = negative pulse, 10 = illegal.
- sym_en  input  1  symbol strobe; sym_in is accepted only on clk edges where sym_en=1.
- data_out  output  1  recovered NRZ bit.
- data_valid  output  1  one-cycle strobe qualifying data_out.
- viol_det  output  1  one-cycle pulse: the accepted symbol was decoded as V.
- code_err  output  1  one-cycle pulse: the accepted symbol broke an HDB3 rule.
- err_cnt  output  ERR_W  saturating count of code_err pulses.

## Operation
- Symbols are processed only on accepted edges (sym_en=1); otherwise all state holds and data_valid, viol_det and code_err are 0.
- Pulse classification: the symbol is a pulse if it is 01 or 11. The first pulse after reset is always B (pulse_seen=0). A later pulse with the same polarity as last_pol is V; otherwise it is B. last_pol and pulse_seen update on every pulse, B or V.
- Delay line: 4 one-bit stages s0 (newest) to s3. On each accept, data_out <= old s3, then shift: s1..s3 <= old s0..s2, s0 <= (pulse && !V).
- V removal: when the accepted symbol is V, the shifted-in s1, s2 and s3 are forced to 0 and s0 is 0. This zeroes V and its 3 predecessors, covering both the 000V and B00V substitutions.
- Fill: a 0..4 saturating fill counter. data_valid=1 on an accept only when fill==4 before the accept. The first 4 accepted symbols after reset produce no output.
- code_err fires on any of the following (several causes in one symbol give a single pulse):
  - sym_in == 10; the symbol is then treated as zero.
  - A V with the same polarity as the previous V (v_seen && pol == last_v_pol).
  - A fourth consecutive zero symbol, tracked by a zero-run counter that saturates at 4 and clears on any pulse.
- err_cnt increments by 1 per code_err and saturates at 2^ERR_W-1.
- viol_det is asserted together with the accept of the V symbol.
- Reset values: data_out 0, data_valid 0, viol_det 0, code_err 0, err_cnt 0, s0..s3 0, fill 0, pulse_seen 0, v_seen 0, last_pol positive, last_v_pol positive, zero-run 0.

## Timing
- All outputs are registered.
- The bit for the symbol accepted at edge k appears on data_out with data_valid=1 after the 4th following accepted edge (latency of 4 accepted symbols). In wall-clock cycles this stretches with sym_en gaps.
- viol_det and code_err for a symbol are valid in the cycle after that symbol's accept edge.
- Simultaneous events: V detection and the output shift occur on the same edge. The bit leaving s3 is the 4th predecessor of V, so it is never cleared.
- Reset mid-stream: asserting rst_n low clears all state immediately and discards any partially filled delay line. After release, decoding restarts with a fresh fill.
- There is no flush input: the last 4 symbols of a stream are emitted only when further symbols are accepted.

## Test plan
- Reset check: hold rst_n=0 while driving symbols with sym_en=1 -> all outputs 0 and err_cnt 0. Release, then accept 4 symbols -> data_valid stays 0 for all four.
- 000V: after reset feed 01,00,00,00,01,11, then 00 x4 (sym_en=1 every cycle). Required:
  - viol_det on the 5th symbol only.
  - Decoded bits 1,0,0,0,0,1,0,0,0,0.
  - code_err pulses on the 4th trailing zero (symbol 10).
- B00V: after reset feed 01,11,01,00,00,01, then 11,00,00,00. Required:
  - viol_det on the 6th symbol.
  - Decoded bits 1,1,0,0,0,0,1,0,0,0.
  - No code_err.
- Illegal and repeated-V errors:
  - Symbol 10 -> code_err once; the symbol decodes as 0.
  - Two V's of equal polarity (01,00,00,00,01,11,00,00,11 is V-; then 11,00,00,00,11 with prior V+ legal) -> code_err on the offending V; err_cnt counts each.
- Gapped strobes and saturation:
  - Repeat the 000V case with sym_en=1 only every 3rd cycle -> identical bit sequence; no output or state change on idle cycles.
  - With ERR_W=2, inject 5 illegal symbols -> err_cnt stops at 3.
- Reset mid-operation: assert rst_n after 2 symbols of a 000V pattern -> no V detected. Restart with 01,00,00,00,01 -> the 5th symbol is flagged as V.

Source files
------------

// File: rtl/hdb3_decoder.sv
// HDB3 receive decoder: classifies bipolar pulses as B or V, strips 000V/B00V substitutions
// through a 4-stage delay line, and flags line-code errors with a saturating counter.
module hdb3_decoder #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sym_in,
  input  logic             sym_en,
  output logic             data_out,
  output logic             data_valid,
  output logic             viol_det,
  output logic             code_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

  logic [3:0]       dly_q, dly_d;
  logic [2:0]       fill_q, fill_d;
  logic [2:0]       zrun_q, zrun_d;
  logic             pulse_seen_q, pulse_seen_d;
  logic             v_seen_q, v_seen_d;
  logic             last_pol_q, last_pol_d;
  logic             last_v_pol_q, last_v_pol_d;
  logic             data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             viol_q, viol_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic is_pulse, pol, illegal, is_v, rep_v, zero4;

  // sym_in[0] marks a pulse (01/11); sym_in[1] is its polarity, 1 = negative.
  assign is_pulse = sym_in[0];
  assign pol      = sym_in[1];
  assign illegal  = (sym_in == 2'b10);
  assign is_v     = is_pulse && pulse_seen_q && (pol == last_pol_q);
  assign rep_v    = is_v && v_seen_q && (pol == last_v_pol_q);
  assign zero4    = !is_pulse && (zrun_q == 3'd3);

  always_comb begin
    dly_d        = dly_q;
    fill_d       = fill_q;
    zrun_d       = zrun_q;
    pulse_seen_d = pulse_seen_q;
    v_seen_d     = v_seen_q;
    last_pol_d   = last_pol_q;
    last_v_pol_d = last_v_pol_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    viol_d       = 1'b0;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt_q;

    if (sym_en) begin
      data_out_d   = dly_q[3];
      data_valid_d = (fill_q == 3'd4);
      fill_d       = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
      // A V clears itself and its three predecessors; the bit leaving s3 is untouched.
      dly_d        = is_v ? 4'b0000 : {dly_q[2:0], is_pulse};

      if (is_pulse) begin
        pulse_seen_d = 1'b1;
        last_pol_d   = pol;
        zrun_d       = 3'd0;
      end else begin
        zrun_d = (zrun_q == 3'd4) ? 3'd4 : zrun_q + 3'd1;
      end

      if (is_v) begin
        v_seen_d     = 1'b1;
        last_v_pol_d = pol;
      end

      viol_d = is_v;
      err_d  = illegal || rep_v || zero4;
      if (err_d && (err_cnt_q != ErrMax)) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q        <= 4'b0000;
      fill_q       <= 3'd0;
      zrun_q       <= 3'd0;
      pulse_seen_q <= 1'b0;
      v_seen_q     <= 1'b0;
      last_pol_q   <= 1'b0;
      last_v_pol_q <= 1'b0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      viol_q       <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      dly_q        <= dly_d;
      fill_q       <= fill_d;
      zrun_q       <= zrun_d;
      pulse_seen_q <= pulse_seen_d;
      v_seen_q     <= v_seen_d;
      last_pol_q   <= last_pol_d;
      last_v_pol_q <= last_v_pol_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      viol_q       <= viol_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign viol_det   = viol_q;
  assign code_err   = err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_hdb3_decoder.sv
// Scoreboard bench for hdb3_decoder: stimulus pushes hand-derived events and bits,
// a clocked monitor pops and compares them for an 8-bit and a 2-bit error counter instance.
module tb_hdb3_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sym_in;
  logic       sym_en;

  logic       data_out, data_valid, viol_det, code_err;
  logic [7:0] err_cnt;
  logic       d2_data_out, d2_data_valid, d2_viol_det, d2_code_err;
  logic [1:0] d2_err_cnt;

  hdb3_decoder #(.ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_en(sym_en),
    .data_out(data_out), .data_valid(data_valid), .viol_det(viol_det),
    .code_err(code_err), .err_cnt(err_cnt)
  );

  hdb3_decoder #(.ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_en(sym_en),
    .data_out(d2_data_out), .data_valid(d2_data_valid), .viol_det(d2_viol_det),
    .code_err(d2_code_err), .err_cnt(d2_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic v; logic e;} ev_t;

  ev_t  ev_q[$];
  logic data_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   gap      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle, sample what was accepted at the rising edge, check at the falling edge.
  initial begin : monitor
    logic acc;
    int   exp8, exp2;
    ev_t  ev;
    logic b;
    exp8 = 0;
    exp2 = 0;
    forever begin
      @(posedge clk);
      acc = sym_en && rst_n;
      @(negedge clk);
      if (!rst_n) begin
        exp8 = 0;
        exp2 = 0;
        chk("rst_data_out", {31'd0, data_out}, 0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 0);
        chk("rst_err_cnt2", {30'd0, d2_err_cnt}, 0);
      end
      if (acc) begin
        if (ev_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ev_underflow: accept with no expected event at %0t", $time);
        end else begin
          ev = ev_q.pop_front();
          if (ev.e) begin
            if (exp8 < 255) exp8++;
            if (exp2 < 3) exp2++;
          end
          chk("viol_det", {31'd0, viol_det}, {31'd0, ev.v});
          chk("code_err", {31'd0, code_err}, {31'd0, ev.e});
          chk("d2_viol_det", {31'd0, d2_viol_det}, {31'd0, ev.v});
          chk("err_cnt", {24'd0, err_cnt}, exp8);
          chk("err_cnt2", {30'd0, d2_err_cnt}, exp2);
        end
      end else begin
        chk("idle_quiet", {29'd0, data_valid, viol_det, code_err}, 0);
        chk("idle_quiet2", {29'd0, d2_data_valid, d2_viol_det, d2_code_err}, 0);
      end
      if (data_valid) begin
        if (data_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_valid: data_valid=1 with no expected bit at %0t", $time);
        end else begin
          b = data_q.pop_front();
          chk("data_out", {31'd0, data_out}, {31'd0, b});
          chk("d2_data_out", {31'd0, d2_data_out}, {31'd0, b});
        end
      end
    end
  end

  task automatic s(input logic [1:0] sym, input logic v, input logic e, input logic b,
                   input bit hb);
    @(posedge clk);
    #1;
    sym_in = sym;
    sym_en = 1'b1;
    ev_q.push_back({v, e});
    if (hb) data_q.push_back(b);
    repeat (gap) begin
      @(posedge clk);
      #1;
      sym_en = 1'b0;
      sym_in = 2'($urandom);
    end
  endtask

  task automatic zeros(input int n);
    repeat (n) s(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      sym_en = 1'b0;
    end
  endtask

  // Four alternating B pulses push the last real bits out; their own bits stay inside.
  task automatic flush(input logic [1:0] p);
    logic [1:0] o;
    o = p ^ 2'b10;
    s(p, 1'b0, 1'b0, 1'b0, 1'b0);
    s(o, 1'b0, 1'b0, 1'b0, 1'b0);
    s(p, 1'b0, 1'b0, 1'b0, 1'b0);
    s(o, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle(1);
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    sym_en = 1'b1;
    sym_in = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    sym_en = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic end_test(input string name);
    idle(3);
    chk({name, "_bits_drained"}, data_q.size(), 0);
    chk({name, "_events_drained"}, ev_q.size(), 0);
  endtask

  task automatic tc_000v();
    s(2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    zeros(3);
    s(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
    s(2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    zeros(3);
    s(2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    flush(2'b01);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    rst_n  = 1'b0;
    sym_en = 1'b1;
    sym_in = 2'b01;
    repeat (4) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    sym_en = 1'b0;

    // Fresh fill: four B pulses, no output expected.
    s(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    s(2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    s(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    s(2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    end_test("fill");

    do_reset();
    tc_000v();
    end_test("000v");

    do_reset();
    s(2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    s(2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    s(2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    zeros(2);
    s(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
    s(2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    zeros(3);
    flush(2'b01);
    end_test("b00v");

    // Legal V+/V- pair, two repeated V-, illegal symbols, illegal as fourth zero.
    do_reset();
    s(2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    zeros(3);
    s(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
    s(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    zeros(2);
    s(2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
    s(2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
    zeros(3);
    s(2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
    s(2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    s(2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    zeros(2);
    s(2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    s(2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    flush(2'b11);
    end_test("errors");

    do_reset();
    gap = 2;
    tc_000v();
    gap = 0;
    end_test("gapped");

    do_reset();
    repeat (5) s(2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    flush(2'b01);
    end_test("saturate");

    // Reset two symbols into a 000V pattern, then restart it.
    do_reset();
    s(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    s(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    s(2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    zeros(3);
    s(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
    flush(2'b11);
    end_test("midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
